// File: rtl/shift_right_pipe_if.sv
// Valid/ready bundle for the two-stage right shifter: request side (in_*) and
// result side (out_*). The shifter attaches through the slave modport.
interface shift_right_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic             in_arith;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_arith, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_arith, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_right_pipe.sv
// Two-stage logarithmic right shifter (logical or arithmetic per transaction).
// Stage 1 resolves shifts of 1/2/4, the output stage resolves 8, 16, ...
module shift_right_pipe #(
  parameter int WIDTH = 32
) (
  input logic               clock,
  input logic               reset,
  shift_right_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int HIW = SHW - 3;

  logic [WIDTH-1:0] s1_shift_s;
  logic [WIDTH-1:0] s2_shift_s;
  logic             fill_s;
  logic             s2_load_s;
  logic             in_ready_s;
  logic             in_fire_s;

  logic [WIDTH-1:0] s1_data_r;
  logic [HIW-1:0]   s1_hi_r;
  logic             s1_fill_r;
  logic             s1_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;

  // Shift right by amt, driving the vacated MSBs with the fill bit.
  function automatic logic [WIDTH-1:0] shr_fill(input logic [WIDTH-1:0] v,
                                                input int unsigned     amt,
                                                input logic            f);
    logic [WIDTH-1:0] mask;
    mask = ~({WIDTH{1'b1}} >> amt);
    if (f) begin
      return (v >> amt) | mask;
    end else begin
      return v >> amt;
    end
  endfunction

  // First shift stage: fine amounts 1, 2 and 4 from in_shamt[2:0].
  always_comb begin
    fill_s     = bus.in_arith & bus.in_data[WIDTH-1];
    s1_shift_s = bus.in_data;
    for (int k = 0; k < 3; k++) begin
      if (bus.in_shamt[k]) begin
        s1_shift_s = shr_fill(s1_shift_s, 32'd1 << k, fill_s);
      end else begin
        s1_shift_s = s1_shift_s;
      end
    end
  end

  // Second shift stage: coarse amounts 8, 16, ... from the stored upper shamt bits.
  always_comb begin
    s2_shift_s = s1_data_r;
    for (int k = 3; k < SHW; k++) begin
      if (s1_hi_r[k-3]) begin
        s2_shift_s = shr_fill(s2_shift_s, 32'd1 << k, s1_fill_r);
      end else begin
        s2_shift_s = s2_shift_s;
      end
    end
  end

  // Pipeline advance: S1 may refill whenever its content moves on in the same edge.
  always_comb begin
    s2_load_s  = s1_valid_r & (~out_valid_r | bus.out_ready);
    in_ready_s = ~reset & (~s1_valid_r | s2_load_s);
    in_fire_s  = bus.in_valid & in_ready_s;
  end

  // Stage 1 register: partial result, remaining shift bits and fill bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {WIDTH{1'b0}};
      s1_hi_r    <= {HIW{1'b0}};
      s1_fill_r  <= 1'b0;
    end else if (in_fire_s) begin
      s1_valid_r <= 1'b1;
      s1_data_r  <= s1_shift_s;
      s1_hi_r    <= bus.in_shamt[SHW-1:3];
      s1_fill_r  <= fill_s;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Output register: holds the result stable until the downstream takes it.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
    end else if (s2_load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= s2_shift_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
endmodule

// File: tb/tb_shift_right_pipe.sv
// Directed bench for shift_right_pipe: hand-computed vectors pushed into a
// scoreboard FIFO, plus a short randomised run against a reference shift.
module tb_shift_right_pipe;
  logic clock;
  logic reset;
  int   checks    = 0;
  int   failures  = 0;
  int   out_fires = 0;
  logic [31:0] q[$];
  logic        acc;
  int          fires0;
  int          sent;
  int          guard;
  logic        seen_valid;
  logic [31:0] stream_exp [8];

  shift_right_pipe_if #(.WIDTH(32)) bif ();

  shift_right_pipe #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shr(input logic [31:0] d, input logic [4:0] s, input logic a);
    logic signed [31:0] sd;
    sd = d;
    if (a) return 32'(sd >>> s);
    return d >> s;
  endfunction

  // One clock cycle: drive, sample mid-cycle, score any output transfer, advance.
  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] s, input logic a,
                      input logic ordy, input logic [31:0] exp, output logic accepted);
    bif.in_valid  = v;
    bif.in_data   = d;
    bif.in_shamt  = s;
    bif.in_arith  = a;
    bif.out_ready = ordy;
    #1;
    accepted = v & bif.in_ready;
    if (bif.out_valid && ordy) begin
      out_fires++;
      if (q.size() == 0) begin
        check("spurious_out", {31'b0, bif.out_valid}, 32'd0);
      end else begin
        check("scoreboard", bif.out_data, q.pop_front());
      end
    end
    if (accepted) q.push_back(exp);
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0, a);
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    stream_exp = '{32'hF0, 32'h78, 32'h3C, 32'h1E, 32'h0F, 32'h07, 32'h03, 32'h01};
    reset         = 1'b1;
    bif.in_valid  = 1'b1;
    bif.in_data   = 32'hDEADBEEF;
    bif.in_shamt  = 5'd3;
    bif.in_arith  = 1'b1;
    bif.out_ready = 1'b1;

    // Reset state; inputs offered during reset must be ignored.
    repeat (2) @(posedge clock);
    #2;
    check("rst_in_ready", {31'b0, bif.in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, bif.out_valid}, 32'd0);
    check("rst_out_data", bif.out_data, 32'd0);
    @(posedge clock);
    #1;
    reset        = 1'b0;
    bif.in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", {31'b0, bif.in_ready}, 32'd1);
    @(posedge clock);
    #1;
    repeat (3) step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0, acc);

    // Passthrough with two-cycle latency.
    step(1'b1, 32'h12345678, 5'd0, 1'b0, 1'b1, 32'h12345678, acc);
    check("pass_acc", {31'b0, acc}, 32'd1);
    check("pass_lat1", {31'b0, bif.out_valid}, 32'd0);
    step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0, acc);
    check("pass_lat2", {31'b0, bif.out_valid}, 32'd1);
    check("pass_data", bif.out_data, 32'h12345678);
    drain();

    // Logical vs arithmetic, including the shamt = 31 corners.
    step(1'b1, 32'h80000000, 5'd4,  1'b0, 1'b1, 32'h08000000, acc);
    step(1'b1, 32'h80000000, 5'd4,  1'b1, 1'b1, 32'hF8000000, acc);
    step(1'b1, 32'h80000000, 5'd31, 1'b1, 1'b1, 32'hFFFFFFFF, acc);
    step(1'b1, 32'h7FFFFFFF, 5'd31, 1'b1, 1'b1, 32'h00000000, acc);
    step(1'b1, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b1, 32'h00000001, acc);
    step(1'b1, 32'hC3000081, 5'd9,  1'b1, 1'b1, 32'hFFE18000, acc);
    drain();

    // Streaming: eight back-to-back inputs, outputs with no bubbles.
    fires0 = out_fires;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h000000F0, 5'(i), 1'b0, 1'b1, stream_exp[i], acc);
      check("stream_acc", {31'b0, acc}, 32'd1);
      if (i == 1) check("stream_latency", 32'(out_fires - fires0), 32'd0);
    end
    step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0, acc);
    step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0, acc);
    check("stream_count", 32'(out_fires - fires0), 32'd8);
    drain();

    // Backpressure: A and B fill the pipe, C waits, then all drain in order.
    step(1'b1, 32'hF0F00000, 5'd8,  1'b1, 1'b0, 32'hFFF0F000, acc);
    check("bp_acc_a", {31'b0, acc}, 32'd1);
    step(1'b1, 32'h0000FF00, 5'd12, 1'b0, 1'b0, 32'h0000000F, acc);
    check("bp_acc_b", {31'b0, acc}, 32'd1);
    step(1'b1, 32'hA5A5A5A5, 5'd16, 1'b1, 1'b0, 32'hFFFFA5A5, acc);
    check("bp_block_c", {31'b0, acc}, 32'd0);
    step(1'b1, 32'hA5A5A5A5, 5'd16, 1'b1, 1'b0, 32'hFFFFA5A5, acc);
    check("bp_block_c2", {31'b0, acc}, 32'd0);
    check("bp_hold_a", bif.out_data, 32'hFFF0F000);
    step(1'b1, 32'hA5A5A5A5, 5'd16, 1'b1, 1'b1, 32'hFFFFA5A5, acc);
    check("bp_simul_acc_c", {31'b0, acc}, 32'd1);
    drain();
    step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0, acc);
    check("bp_idle", {31'b0, bif.out_valid}, 32'd0);

    // Reset with two transactions in flight.
    step(1'b1, 32'h11112222, 5'd1, 1'b0, 1'b0, 32'h08889111, acc);
    step(1'b1, 32'h33334444, 5'd2, 1'b0, 1'b0, 32'h0CCCD111, acc);
    reset         = 1'b1;
    bif.in_valid  = 1'b1;
    bif.out_ready = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'b0, bif.in_ready}, 32'd0);
    @(posedge clock);
    #1;
    reset        = 1'b0;
    bif.in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, bif.out_valid}, 32'd0);
    check("mid_rst_out_data", bif.out_data, 32'd0);
    check("mid_rst_in_ready_after", {31'b0, bif.in_ready}, 32'd1);
    q.delete();
    @(posedge clock);
    #1;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen_valid = seen_valid | bif.out_valid;
      step(1'b0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd0, acc);
    end
    check("mid_rst_no_stale", {31'b0, seen_valid}, 32'd0);

    // Randomised traffic against the reference shift.
    sent  = 0;
    guard = 0;
    while (sent < 400 && guard < 5000) begin
      logic [31:0] d;
      logic [4:0]  s;
      logic        a;
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      a = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), d, s, a, 1'($urandom_range(0, 3) != 0), ref_shr(d, s, a), acc);
      if (acc) sent++;
      guard++;
    end
    check("random_sent", 32'(sent), 32'd400);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
